timer_input_capture: RTL and testbench

Input-capture unit for the timer IP. It synchronises an asynchronous external event pin, detects the selected edge, and latches the current timer count into a small show-ahead FIFO. Firmware or downstream logic reads timestamps with a pop handshake. It is the reading end of the up/down counter: it consumes that counter's `count` bus and does not drive it.

---
 rtl/timer_input_capture.sv | 64 ++++++
 tb/tb_timer_input_capture.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/timer_input_capture.sv
// timer_input_capture: synchronised edge detector that timestamps events into a show-ahead FIFO
module timer_input_capture #(
  parameter int COUNTER_BIT_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [1:0]                   edge_sel,
  input  logic                         capture_in,
  input  logic [COUNTER_BIT_WIDTH-1:0] count,
  input  logic                         rd_en,
  input  logic                         overflow_clr,
  output logic [COUNTER_BIT_WIDTH-1:0] capture_value,
  output logic                         capture_edge,
  output logic                         capture_valid,
  output logic [AW:0]                  fifo_level,
  output logic                         overflow
);
  logic [2:0] sync_q;
  logic [1:0] prime_q, prime_d;
  logic [COUNTER_BIT_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] level_q, level_d;
  logic ovf_q, ovf_d;
  logic rise, fall, evt, push, pop, full, wr, drop;
  always_comb begin
    rise = sync_q[1] & ~sync_q[2];
    fall = ~sync_q[1] & sync_q[2];
    evt = (rise & ~edge_sel[0]) | (fall & (edge_sel[0] ^ edge_sel[1]));
    push = evt & enable & (prime_q == 2'd3);
    full = level_q == (AW+1)'(FIFO_DEPTH);
    pop = rd_en & (level_q != '0);
    wr = push & (~full | pop);
    drop = push & full & ~pop;
    level_d = (wr & ~pop) ? level_q + (AW+1)'(1) : (pop & ~wr) ? level_q - (AW+1)'(1) : level_q;
    ovf_d = drop | (ovf_q & ~overflow_clr);
    prime_d = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prime_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync_q <= {sync_q[1:0], capture_in};
      prime_q <= prime_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      if (wr) mem_q[wr_q] <= {rise, count};
      if (wr) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
    end
  end
  assign capture_valid = level_q != '0;
  assign {capture_edge, capture_value} = capture_valid ? mem_q[rd_q] : '0;
  assign fifo_level = level_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_timer_input_capture.sv
// tb_timer_input_capture: table plus scoreboard bench for the input-capture FIFO
module tb_timer_input_capture;
  logic clk = 0, rst = 0, enable = 1, capture_in = 1, rd_en = 0, overflow_clr = 0;
  logic [1:0] edge_sel = 2'b00;
  logic [7:0] count = 0, c;
  logic [7:0] capture_value;
  logic capture_edge, capture_valid, overflow;
  logic [2:0] fifo_level;
  typedef struct { logic [1:0] sel; logic en; logic pin; int lvl; logic ovf; } vec_t;
  vec_t tbl [11];
  logic [8:0] sb [$];
  int n_vec = 0, n_bad = 0;

  timer_input_capture dut (
    .clk(clk), .rst(rst), .enable(enable), .edge_sel(edge_sel), .capture_in(capture_in),
    .count(count), .rd_en(rd_en), .overflow_clr(overflow_clr), .capture_value(capture_value),
    .capture_edge(capture_edge), .capture_valid(capture_valid), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      count = count + 8'd1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop1();
    rd_en = 1;
    tick(1);
    rd_en = 0;
  endtask

  initial begin
    tbl = '{'{2'b01, 1'b1, 1'b1, 0, 1'b0}, '{2'b01, 1'b1, 1'b0, 1, 1'b0},
            '{2'b11, 1'b1, 1'b1, 1, 1'b0}, '{2'b00, 1'b0, 1'b0, 1, 1'b0},
            '{2'b00, 1'b0, 1'b1, 1, 1'b0}, '{2'b10, 1'b0, 1'b0, 1, 1'b0},
            '{2'b00, 1'b1, 1'b1, 2, 1'b0}, '{2'b00, 1'b1, 1'b0, 2, 1'b0},
            '{2'b10, 1'b1, 1'b1, 3, 1'b0}, '{2'b10, 1'b1, 1'b0, 4, 1'b0},
            '{2'b00, 1'b1, 1'b1, 4, 1'b1}};
    tick(3);
    chk("reset_level", fifo_level, 0);
    chk("reset_valid", capture_valid, 0);
    chk("reset_ovf", overflow, 0);
    rst = 1;
    tick(10);
    chk("prime_level", fifo_level, 0);
    chk("prime_valid", capture_valid, 0);

    capture_in = 0;
    tick(4);
    count = 8'h10;
    capture_in = 1;
    tick(2);
    chk("rise_early_level", fifo_level, 0);
    tick(1);
    chk("rise_value", capture_value, 8'h12);
    chk("rise_edge", capture_edge, 1);
    chk("rise_level", fifo_level, 1);
    capture_in = 0;
    tick(4);
    chk("fall_ignored", fifo_level, 1);
    pop1();
    chk("pop_empty", fifo_level, 0);

    edge_sel = 2'b10;
    count = 8'h20;
    capture_in = 1;
    tick(5);
    capture_in = 0;
    tick(3);
    chk("both_level2", fifo_level, 2);
    chk("both_v0", capture_value, 8'h22);
    chk("both_e0", capture_edge, 1);
    pop1();
    chk("both_level1", fifo_level, 1);
    chk("both_v1", capture_value, 8'h27);
    chk("both_e1", capture_edge, 0);
    pop1();
    chk("both_level0", fifo_level, 0);
    chk("both_valid0", capture_valid, 0);

    for (int i = 0; i < 11; i++) begin
      edge_sel = tbl[i].sel;
      enable = tbl[i].en;
      capture_in = tbl[i].pin;
      c = count;
      tick(3);
      if (tbl[i].en && ((tbl[i].pin && !tbl[i].sel[0]) ||
          (!tbl[i].pin && (tbl[i].sel == 2'b01 || tbl[i].sel == 2'b10))) && sb.size() < 4)
        sb.push_back({tbl[i].pin, c + 8'd2});
      chk($sformatf("vec%0d_level", i), fifo_level, tbl[i].lvl);
      chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].ovf);
      tick(1);
    end

    overflow_clr = 1;
    tick(1);
    overflow_clr = 0;
    chk("ovf_clr", overflow, 0);

    capture_in = 0;
    tick(4);
    chk("full_head_before", {capture_edge, capture_value}, sb[0]);
    capture_in = 1;
    c = count;
    tick(2);
    rd_en = 1;
    tick(1);
    rd_en = 0;
    void'(sb.pop_front());
    sb.push_back({1'b1, c + 8'd2});
    chk("full_pp_level", fifo_level, 4);
    chk("full_pp_ovf", overflow, 0);

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), {capture_edge, capture_value}, sb[0]);
      pop1();
      void'(sb.pop_front());
    end
    chk("drain_level", fifo_level, 0);
    chk("drain_valid", capture_valid, 0);

    edge_sel = 2'b10;
    enable = 1;
    capture_in = 0;
    tick(4);
    capture_in = 1;
    tick(4);
    chk("pre_rst_level", fifo_level, 2);
    rst = 0;
    #2;
    chk("rst_level", fifo_level, 0);
    chk("rst_valid", capture_valid, 0);
    chk("rst_value", capture_value, 0);
    chk("rst_edge", capture_edge, 0);
    chk("rst_ovf", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
